// File: rtl/vendas_pkg.sv
// Shared types and constants for the vending-machine sequencing controller.
package vendas_pkg;

  localparam int LARGURA_CREDITO = 4;
  localparam int LARGURA_PRODUTO = 3;
  localparam int LARGURA_SOMA    = LARGURA_CREDITO + 1;
  localparam logic [LARGURA_SOMA-1:0] CREDITO_MAX = 5'd15;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    COLETA    = 3'd1,
    AVALIA    = 3'd2,
    RESULTADO = 3'd3,
    ENTREGA   = 3'd4,
    DEVOLVE   = 3'd5
  } estado_t;

  // Price in credit units; zero marks an invalid product code.
  function automatic logic [LARGURA_CREDITO-1:0] preco_produto(input logic [LARGURA_PRODUTO-1:0] produto);
    case (produto)
      3'd1:    preco_produto = 4'd2;
      3'd2:    preco_produto = 4'd4;
      3'd3:    preco_produto = 4'd5;
      3'd4:    preco_produto = 4'd6;
      3'd5:    preco_produto = 4'd7;
      3'd6:    preco_produto = 4'd8;
      default: preco_produto = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Loadable down-counter; expirou is high while the count sits at zero.
module contador_timeout #(
  parameter int LARGURA = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               recarregar,
  input  logic               habilitar,
  input  logic [LARGURA-1:0] carga,
  output logic               expirou
);

  logic [LARGURA-1:0] contagem;

  // Reload has priority over counting; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      contagem <= {LARGURA{1'b0}};
    end else if (recarregar) begin
      contagem <= carga;
    end else if (habilitar && (contagem != {LARGURA{1'b0}})) begin
      contagem <= contagem - LARGURA'(1);
    end
  end

  assign expirou = (contagem == {LARGURA{1'b0}});

endmodule

// File: rtl/controle_vendas.sv
// Vending-machine sequencer: credit accumulation, compare strobe, verdict
// sampling and timed dispense/refund pulses.
module controle_vendas
  import vendas_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int T_PULSO        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       moedaIn,
  input  logic [1:0]                 moedaValor,
  input  logic [LARGURA_PRODUTO-1:0] produtoSel,
  input  logic                       confirmar,
  input  logic                       cancelar,
  input  logic                       liberarProduto,
  input  logic                       devolverMoedas,
  output logic [LARGURA_CREDITO-1:0] valorMoedas,
  output logic [LARGURA_PRODUTO-1:0] valorProduto,
  output logic                       enable,
  output logic                       resetComp,
  output logic                       entregar,
  output logic                       devolver,
  output logic                       rejeitarMoeda,
  output logic                       ocupado
);

  localparam int LT = $clog2(TIMEOUT_CICLOS + 1);
  localparam int LP = $clog2(T_PULSO + 1);

  estado_t                 estado;
  logic [LARGURA_SOMA-1:0] soma;
  logic                    moeda_valida;
  logic                    moeda_aceita;
  logic                    moeda_rejeitada;
  logic                    em_coleta;
  logic                    em_pulso;
  logic                    expirou_timeout;
  logic                    expirou_pulso;

  // The sum is one bit wider than credit so overflow is caught before commit.
  assign soma            = {1'b0, valorMoedas} + {3'b000, moedaValor};
  assign moeda_valida    = (moedaValor == 2'd1) || (moedaValor == 2'd2);
  assign em_coleta       = (estado == COLETA);
  assign em_pulso        = (estado == ENTREGA) || (estado == DEVOLVE);
  assign moeda_aceita    = moedaIn && moeda_valida && (soma <= CREDITO_MAX)
                           && ((estado == OCIOSO) || em_coleta)
                           && !confirmar && !cancelar;
  assign moeda_rejeitada = moedaIn && !moeda_aceita;

  contador_timeout #(.LARGURA(LT)) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .recarregar (moeda_aceita),
    .habilitar  (em_coleta),
    .carga      (LT'(TIMEOUT_CICLOS - 1)),
    .expirou    (expirou_timeout)
  );

  // Held at T_PULSO-1 outside the pulse states so it is armed on entry.
  contador_timeout #(.LARGURA(LP)) u_pulso (
    .clk        (clk),
    .reset      (reset),
    .recarregar (!em_pulso),
    .habilitar  (em_pulso),
    .carga      (LP'(T_PULSO - 1)),
    .expirou    (expirou_pulso)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= OCIOSO;
      valorMoedas   <= 4'd0;
      valorProduto  <= 3'd0;
      enable        <= 1'b0;
      resetComp     <= 1'b0;
      entregar      <= 1'b0;
      devolver      <= 1'b0;
      rejeitarMoeda <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      enable        <= 1'b0;
      resetComp     <= 1'b0;
      rejeitarMoeda <= moeda_rejeitada;
      case (estado)
        OCIOSO: begin
          if (moeda_aceita) begin
            valorMoedas <= soma[LARGURA_CREDITO-1:0];
            estado      <= COLETA;
          end
        end
        COLETA: begin
          if (cancelar) begin
            estado   <= DEVOLVE;
            devolver <= 1'b1;
            ocupado  <= 1'b1;
          end else if (confirmar) begin
            valorProduto <= produtoSel;
            estado       <= AVALIA;
            enable       <= 1'b1;
            ocupado      <= 1'b1;
          end else if (moeda_aceita) begin
            valorMoedas <= soma[LARGURA_CREDITO-1:0];
          end else if (expirou_timeout) begin
            estado   <= DEVOLVE;
            devolver <= 1'b1;
            ocupado  <= 1'b1;
          end
        end
        AVALIA: begin
          estado <= RESULTADO;
        end
        RESULTADO: begin
          // Only an unambiguous "release" verdict dispenses; everything else refunds.
          if (liberarProduto && !devolverMoedas) begin
            estado   <= ENTREGA;
            entregar <= 1'b1;
          end else begin
            estado   <= DEVOLVE;
            devolver <= 1'b1;
          end
        end
        ENTREGA, DEVOLVE: begin
          if (expirou_pulso) begin
            estado      <= OCIOSO;
            entregar    <= 1'b0;
            devolver    <= 1'b0;
            ocupado     <= 1'b0;
            valorMoedas <= 4'd0;
            resetComp   <= 1'b1;
          end
        end
        default: begin
          estado      <= OCIOSO;
          valorMoedas <= 4'd0;
          entregar    <= 1'b0;
          devolver    <= 1'b0;
          ocupado     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_vendas.sv
// Directed scoreboard bench for controle_vendas with a short timeout.
module tb_controle_vendas;
  import vendas_pkg::*;

  localparam int TP = 4;
  localparam int TO = 20;

  logic       clk;
  logic       reset;
  logic       moedaIn;
  logic [1:0] moedaValor;
  logic [2:0] produtoSel;
  logic       confirmar;
  logic       cancelar;
  logic       liberarProduto;
  logic       devolverMoedas;
  logic [3:0] valorMoedas;
  logic [2:0] valorProduto;
  logic       enable;
  logic       resetComp;
  logic       entregar;
  logic       devolver;
  logic       rejeitarMoeda;
  logic       ocupado;

  typedef struct {
    string       tag;
    logic [13:0] valor;
  } item_t;

  item_t      fila[$];
  int         n_assert = 0;
  int         n_falha  = 0;
  logic [3:0] cred;
  logic [2:0] vp;

  controle_vendas #(.TIMEOUT_CICLOS(TO), .T_PULSO(TP)) dut (
    .clk            (clk),
    .reset          (reset),
    .moedaIn        (moedaIn),
    .moedaValor     (moedaValor),
    .produtoSel     (produtoSel),
    .confirmar      (confirmar),
    .cancelar       (cancelar),
    .liberarProduto (liberarProduto),
    .devolverMoedas (devolverMoedas),
    .valorMoedas    (valorMoedas),
    .valorProduto   (valorProduto),
    .enable         (enable),
    .resetComp      (resetComp),
    .entregar       (entregar),
    .devolver       (devolver),
    .rejeitarMoeda  (rejeitarMoeda),
    .ocupado        (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic espera(input string tag, input logic [3:0] vm, input logic en, input logic rc,
                        input logic ent, input logic dev, input logic rej, input logic oc);
    item_t it;
    it.tag   = tag;
    it.valor = {vm, vp, en, rc, ent, dev, rej, oc};
    fila.push_back(it);
  endtask

  task automatic confere();
    item_t       it;
    logic [13:0] o;
    o = {valorMoedas, valorProduto, enable, resetComp, entregar, devolver, rejeitarMoeda, ocupado};
    n_assert++;
    if (fila.size() == 0) begin
      n_falha++;
      $error("FAIL fila_vazia: observado %b esperado item na fila", o);
    end else begin
      it = fila.pop_front();
      assert (o === it.valor) else begin
        n_falha++;
        $error("FAIL %s: observado %b esperado %b", it.tag, o, it.valor);
      end
    end
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
    moedaIn    = 1'b0;
    moedaValor = 2'd0;
    confirmar  = 1'b0;
    cancelar   = 1'b0;
  endtask

  task automatic moeda(input logic [1:0] v);
    logic [4:0] s;
    logic       ok;
    s  = {1'b0, cred} + {3'b000, v};
    ok = ((v == 2'd1) || (v == 2'd2)) && (s <= 5'd15);
    if (ok) cred = s[3:0];
    moedaIn    = 1'b1;
    moedaValor = v;
    espera("moeda", cred, 1'b0, 1'b0, 1'b0, 1'b0, !ok, 1'b0);
    passo();
    confere();
  endtask

  task automatic atuador(input logic ent, input logic dev, input logic rej1);
    for (int k = 0; k < TP; k++) begin
      espera(ent ? "entregar" : "devolver", cred, 1'b0, 1'b0, ent, dev,
             (k == 0) ? rej1 : 1'b0, 1'b1);
      passo();
      confere();
    end
    cred = 4'd0;
    espera("resetComp", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    passo();
    confere();
  endtask

  task automatic compra(input logic [2:0] prod);
    logic exato;
    produtoSel = prod;
    confirmar  = 1'b1;
    vp         = prod;
    espera("enable", cred, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    passo();
    confere();
    exato          = (preco_produto(prod) == cred);
    liberarProduto = exato;
    devolverMoedas = !exato;
    espera("resultado", cred, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    passo();
    confere();
    atuador(exato, !exato, 1'b0);
    liberarProduto = 1'b0;
    devolverMoedas = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    moedaIn        = 1'b0;
    moedaValor     = 2'd0;
    produtoSel     = 3'd0;
    confirmar      = 1'b0;
    cancelar       = 1'b0;
    liberarProduto = 1'b0;
    devolverMoedas = 1'b0;
    cred           = 4'd0;
    vp             = 3'd0;
    passo();
    espera("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    passo();
    confere();
    reset = 1'b0;

    // Exact credit 4 for product 2: dispense.
    moeda(2'd2);
    moeda(2'd2);
    compra(3'd2);

    // Credit 3 for product 2: refund.
    moeda(2'd2);
    moeda(2'd1);
    compra(3'd2);

    // Exact credit 5 for product 3.
    moeda(2'd2);
    moeda(2'd2);
    moeda(2'd1);
    compra(3'd3);

    // Overflow and invalid values are rejected, then cancel refunds.
    for (int i = 0; i < 7; i++) moeda(2'd2);
    moeda(2'd2);
    moeda(2'd3);
    moeda(2'd0);
    moeda(2'd1);
    cancelar = 1'b1;
    atuador(1'b0, 1'b1, 1'b0);

    // Inactivity timeout after a single coin.
    moeda(2'd1);
    for (int i = 0; i < TO - 1; i++) begin
      espera("espera_timeout", cred, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      passo();
      confere();
    end
    atuador(1'b0, 1'b1, 1'b0);

    // Confirm, cancel and coin together: cancel wins, coin rejected, no strobe.
    moeda(2'd2);
    moeda(2'd2);
    confirmar  = 1'b1;
    cancelar   = 1'b1;
    moedaIn    = 1'b1;
    moedaValor = 2'd1;
    atuador(1'b0, 1'b1, 1'b1);

    // Reset in the middle of a dispense pulse.
    moeda(2'd2);
    moeda(2'd2);
    produtoSel = 3'd2;
    confirmar  = 1'b1;
    vp         = 3'd2;
    espera("enable_r", cred, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    passo();
    confere();
    liberarProduto = 1'b1;
    espera("resultado_r", cred, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    passo();
    confere();
    for (int i = 0; i < 2; i++) begin
      espera("entregar_r", cred, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      passo();
      confere();
    end
    liberarProduto = 1'b0;
    reset          = 1'b1;
    cred           = 4'd0;
    vp             = 3'd0;
    espera("reset_entrega", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    passo();
    confere();
    reset = 1'b0;
    moeda(2'd1);
    cancelar = 1'b1;
    atuador(1'b0, 1'b1, 1'b0);
    espera("ocioso_final", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    passo();
    confere();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falha);
    $finish;
  end

endmodule

// File: doc/controle_vendas.md
# controle_vendas

Sequencing controller for the vending-machine comparator stage. It accumulates inserted coins into a credit register and latches the product selection. On confirmation it strobes the comparator, samples its verdict, and drives a timed dispense or refund pulse. It also handles cancel, inactivity timeout, coin rejection and comparator re-arming, and sits between the coin/keypad front end and the comparator/actuators.

## Interface
Parameters:
- TIMEOUT_CICLOS, 1000: inactivity cycles in COLETA before automatic refund
- T_PULSO, 4: cycles `entregar`/`devolver` are held high

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- moedaIn  in  1  one-cycle pulse: coin inserted
- moedaValor  in  2  coin value in credit units; 1 or 2 valid, 0/3 invalid
- produtoSel  in  3  product code, sampled on `confirmar`
- confirmar  in  1  one-cycle pulse: purchase request
- cancelar  in  1  one-cycle pulse: abort and refund
- liberarProduto  in  1  comparator verdict: exact credit
- devolverMoedas  in  1  comparator verdict: refund
- valorMoedas  out  4  accumulated credit to comparator
- valorProduto  out  3  latched product code to comparator
- enable  out  1  one-cycle compare strobe
- resetComp  out  1  one-cycle comparator re-arm pulse
- entregar  out  1  dispense actuator, held T_PULSO cycles
- devolver  out  1  refund actuator, held T_PULSO cycles
- rejeitarMoeda  out  1  one-cycle pulse: coin returned unaccepted
- ocupado  out  1  high in AVALIA, RESULTADO, ENTREGA, DEVOLVE

## Operation
- States: OCIOSO, COLETA, AVALIA, RESULTADO, ENTREGA, DEVOLVE.
- OCIOSO:
  - Credit is 0.
  - A valid coin adds its value to credit and moves to COLETA.
  - `confirmar` with zero credit is ignored.
- COLETA:
  - A valid coin adds its value and reloads the timeout counter.
  - `cancelar` moves to DEVOLVE.
  - `confirmar` latches `produtoSel` and moves to AVALIA.
  - Timeout expiry moves to DEVOLVE.
- AVALIA: `enable`=1 for exactly this cycle, then RESULTADO.
- RESULTADO: samples the verdict.
  - `liberarProduto`=1 and `devolverMoedas`=0 moves to ENTREGA.
  - Any other combination, including both or neither, moves to DEVOLVE (fail-safe).
- ENTREGA/DEVOLVE:
  - The matching output is held for T_PULSO cycles.
  - Credit is cleared on the last cycle.
  - Then go to OCIOSO with `resetComp`=1 for one cycle.
- Coin rejection: `rejeitarMoeda` pulses and credit is unchanged when any of these holds:
  - value is 0 or 3;
  - credit + value > 15;
  - state is not OCIOSO/COLETA;
  - the coin arrives in the same cycle as `confirmar` or `cancelar`.
- Simultaneous `confirmar` and `cancelar`: cancel wins.
- Credit arithmetic: 5-bit sum, checked against 15 before commit; no wrap.

## Timing
- Reset values:
  - state OCIOSO;
  - all outputs 0, including `valorMoedas` and `valorProduto`;
  - timeout and pulse counters cleared.
- Reset mid-operation aborts immediately. Outputs are 0 the next cycle and credit is lost (no refund pulse).
- Coin accepted at cycle t: `valorMoedas` updated at t+1.
- `confirmar` at t:
  - `enable` high at t+1;
  - verdict sampled at t+2;
  - actuator high t+3 … t+2+T_PULSO;
  - `resetComp` high at t+3+T_PULSO, in OCIOSO.
- Timeout: expires TIMEOUT_CICLOS cycles after the last accepted coin with no `confirmar`/`cancelar`. `devolver` rises the following cycle.
- All outputs are registered; `rejeitarMoeda` appears one cycle after the offending `moedaIn`.

## Structure
- Shared package `vendas_pkg`:
  - state enum;
  - credit/product widths;
  - product-to-price table (1→2, 2→4, 3→5, 4→6, 5→7, 6→8; others invalid), for bench scoreboarding.
- One sub-module `contador_timeout`: loadable down-counter with `recarregar`, `habilitar` and `expirou`. It is reused for both the timeout and the T_PULSO counts.

## Test plan
- Coins 2, 2 (credit 4), select 2, `confirmar` → `enable` at t+1; comparator says liberar → `entregar` high 4 cycles, credit 0, `resetComp` pulses.
- Coins 2, 1 (credit 3), select 2 → `devolver` high 4 cycles, `entregar` stays 0.
- Credit 14, coin 2 → `rejeitarMoeda` pulse, credit stays 14; coin value 3 → rejected.
- Coin 1, then idle TIMEOUT_CICLOS (bench override 20) → `devolver` at cycle 21 after the coin.
- `confirmar`+`cancelar`+coin in the same cycle at credit 4 → DEVOLVE, coin rejected, no `enable`.
- Reset asserted during ENTREGA → all outputs 0 next cycle; new coin then accepted from credit 0.
